dwu: RTL and testbench

Data write unit: the store-side counterpart of the data register unit. It accepts 64-bit result words from the datapath through a valid/ready interface and buffers them in a small FIFO. Each word is split into two 32-bit memory writes, low half first, at consecutive auto-incrementing addresses, using a req/ack handshake. A store job is started with a base address and a word count, and completion is signalled with a one-cycle done pulse.

---
 rtl/dwu.sv | 119 +++++++++++
 tb/tb_dwu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dwu.sv
// dwu: buffers 64-bit result words and stores each as two 32-bit memory writes
module dwu #(
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              str_start,
    input  logic [ADDR_W-1:0] str_base_addr,
    input  logic [CNT_W-1:0]  str_count,
    input  logic [63:0]       res_data,
    input  logic              res_valid,
    output logic              res_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wr_req,
    input  logic              mem_wr_ack,
    output logic              str_busy,
    output logic              str_done
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT, WR_LO, WR_HI, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  job_q, job_d, rem_q, rem_d, acc_q, acc_d;
    logic [63:0]       hold_q, hold_d;
    logic [63:0]       fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wp_q, rp_q;
    logic [PW:0]       cnt_q;
    logic              full, empty, push, pop;

    assign full       = cnt_q == (PW+1)'(FIFO_DEPTH);
    assign empty      = cnt_q == '0;
    assign str_busy   = state_q != IDLE;
    assign str_done   = state_q == DONE;
    // Readiness comes only from registered state, so a same-cycle pop never frees a slot for a push.
    assign res_ready  = str_busy & ~full & (acc_q < job_q);
    assign push       = res_valid & res_ready;
    assign mem_wr_req = (state_q == WR_LO) | (state_q == WR_HI);
    assign mem_addr   = mem_wr_req ? addr_q : '0;
    assign mem_wdata  = state_q == WR_HI ? hold_q[63:32] : state_q == WR_LO ? hold_q[31:0] : '0;

    // Next-state: job setup, head pop into hold, and address/remaining bookkeeping on each ack.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        job_d   = job_q;
        rem_d   = rem_q;
        acc_d   = acc_q + CNT_W'(push);
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (str_start) begin
                addr_d  = str_base_addr;
                job_d   = str_count;
                rem_d   = str_count;
                acc_d   = '0;
                state_d = str_count == '0 ? DONE : WAIT;
            end
            WAIT: if (!empty) begin
                pop     = 1'b1;
                hold_d  = fifo_q[rp_q];
                state_d = WR_LO;
            end
            WR_LO: if (mem_wr_ack) begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = WR_HI;
            end
            WR_HI: if (mem_wr_ack) begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else if (!empty) begin
                    pop     = 1'b1;
                    hold_d  = fifo_q[rp_q];
                    state_d = WR_LO;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and FIFO pointers; reset flushes the FIFO and abandons any write.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            job_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            hold_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            job_q   <= job_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            hold_q  <= hold_d;
            wp_q    <= wp_q + PW'(push);
            rp_q    <= rp_q + PW'(pop);
            cnt_q   <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge sys_clk) begin
        if (push) fifo_q[wp_q] <= res_data;
    end
endmodule

// File: tb/tb_dwu.sv
// tb_dwu: directed scenario checks for the data write unit
module tb_dwu;
    logic        sys_clk = 0, sys_rst = 1, str_start = 0;
    logic [15:0] str_base_addr = '0;
    logic [7:0]  str_count = '0;
    logic [63:0] res_data = '0;
    logic        res_valid = 0, res_ready, mem_wr_req, mem_wr_ack = 0, str_busy, str_done;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;

    int vec = 0, errs = 0;
    logic [63:0] src[$];
    logic [15:0] wa[$];
    logic [31:0] wd[$];
    int accepted = 0, job_n = 0, ack_delay = 0, wcnt = 0, done_cnt = 0;
    int req_seen = 0, ready_seen = 0, ready_bad = 0, first_drop = -1, stable_err = 0;
    logic push_pending = 0, prev_hold = 0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    dwu dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .str_start(str_start),
        .str_base_addr(str_base_addr), .str_count(str_count),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_req(mem_wr_req),
        .mem_wr_ack(mem_wr_ack), .str_busy(str_busy), .str_done(str_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Source and memory environment, updated on the falling edge.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            push_pending = 0;
            mem_wr_ack = 0;
            wcnt = 0;
            prev_hold = 0;
        end else begin
            if (push_pending) begin
                void'(src.pop_front());
                accepted++;
            end
            if (prev_hold && (mem_wr_req !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_data)) stable_err++;
            if (str_done) done_cnt++;
            if (mem_wr_req) req_seen++;
            if (res_ready) ready_seen++;
            if (res_ready && accepted >= job_n) ready_bad++;
            if (str_busy && !res_ready && accepted < job_n && first_drop < 0) first_drop = accepted;
            res_valid = src.size() > 0;
            res_data = res_valid ? src[0] : '0;
            push_pending = res_valid & res_ready;
            mem_wr_ack = 0;
            prev_hold = 0;
            if (mem_wr_req) begin
                if (wcnt >= ack_delay) begin
                    mem_wr_ack = 1;
                    wa.push_back(mem_addr);
                    wd.push_back(mem_wdata);
                    wcnt = 0;
                end else begin
                    wcnt++;
                    prev_hold = 1;
                    prev_addr = mem_addr;
                    prev_data = mem_wdata;
                end
            end else wcnt = 0;
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete();
        accepted = 0; done_cnt = 0; req_seen = 0; ready_seen = 0; ready_bad = 0; first_drop = -1;
    endtask

    task automatic start(input logic [15:0] base, input logic [7:0] cnt);
        @(negedge sys_clk);
        str_base_addr = base; str_count = cnt; str_start = 1; job_n = cnt;
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            str_start = 0;
            n++;
        end while (str_done !== 1'b1 && n < lim);
        if (str_done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sys_clk);
        vec++; if (res_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %b exp 0", res_ready); end
        vec++; if (mem_wr_req !== 1'b0) begin errs++; $display("FAIL rst_req got %b exp 0", mem_wr_req); end
        vec++; if (mem_addr !== 16'h0) begin errs++; $display("FAIL rst_addr got %h exp 0000", mem_addr); end
        vec++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL rst_wdata got %h exp 0", mem_wdata); end
        vec++; if (str_busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", str_busy); end
        vec++; if (str_done !== 1'b0) begin errs++; $display("FAIL rst_done got %b exp 0", str_done); end
        sys_rst = 0;
        @(negedge sys_clk);
        vec++; if (str_busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b exp 0", str_busy); end
    endtask

    task automatic test_single();
        int n;
        clear_log(); ack_delay = 0;
        src.push_back(64'h1111_2222_3333_4444);
        start(16'h0100, 8'd1);
        wait_done(50, n);
        vec++; if (n != 5) begin errs++; $display("FAIL single_done_cycle got %0d exp 5", n); end
        @(negedge sys_clk);
        vec++; if (str_busy !== 1'b0) begin errs++; $display("FAIL single_busy_after got %b exp 0", str_busy); end
        vec++; if (wa.size() != 2) begin errs++; $display("FAIL single_nwrites got %0d exp 2", wa.size()); end
        else begin
            vec++; if (wa[0] !== 16'h0100 || wd[0] !== 32'h3333_4444) begin errs++; $display("FAIL single_lo got %h/%h exp 0100/33334444", wa[0], wd[0]); end
            vec++; if (wa[1] !== 16'h0101 || wd[1] !== 32'h1111_2222) begin errs++; $display("FAIL single_hi got %h/%h exp 0101/11112222", wa[1], wd[1]); end
        end
    endtask

    task automatic test_back_pressure();
        int n;
        clear_log(); ack_delay = 3;
        for (int i = 0; i < 8; i++) src.push_back({32'hBEEF_0000 + i, 32'hC0DE_0000 + i});
        start(16'h0200, 8'd8);
        wait_done(300, n);
        @(negedge sys_clk);
        vec++; if (n < 0) begin errs++; $display("FAIL bp_timeout got %0d exp done", n); end
        vec++; if (first_drop != 5) begin errs++; $display("FAIL bp_ready_drop got %0d exp 5 accepted (4 buffered)", first_drop); end
        vec++; if (accepted != 8) begin errs++; $display("FAIL bp_accepted got %0d exp 8", accepted); end
        vec++; if (wa.size() != 16) begin errs++; $display("FAIL bp_nwrites got %0d exp 16", wa.size()); end
        else for (int i = 0; i < 8; i++) begin
            vec++; if (wa[2*i] !== 16'(16'h0200 + 2*i) || wd[2*i] !== 32'hC0DE_0000 + i) begin errs++; $display("FAIL bp_lo%0d got %h/%h exp %h/%h", i, wa[2*i], wd[2*i], 16'(16'h0200 + 2*i), 32'hC0DE_0000 + i); end
            vec++; if (wa[2*i+1] !== 16'(16'h0201 + 2*i) || wd[2*i+1] !== 32'hBEEF_0000 + i) begin errs++; $display("FAIL bp_hi%0d got %h/%h exp %h/%h", i, wa[2*i+1], wd[2*i+1], 16'(16'h0201 + 2*i), 32'hBEEF_0000 + i); end
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [15:0] exp_a[4] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
        logic [31:0] exp_d[4] = '{32'hA0, 32'hA1, 32'hB0, 32'hB1};
        clear_log(); ack_delay = 1;
        src.push_back({32'hA1, 32'hA0});
        src.push_back({32'hB1, 32'hB0});
        start(16'hFFFF, 8'd2);
        wait_done(100, n);
        vec++; if (wa.size() != 4) begin errs++; $display("FAIL wrap_nwrites got %0d exp 4", wa.size()); end
        else for (int i = 0; i < 4; i++) begin
            vec++; if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin errs++; $display("FAIL wrap_w%0d got %h/%h exp %h/%h", i, wa[i], wd[i], exp_a[i], exp_d[i]); end
        end
    endtask

    task automatic test_zero_count();
        int n;
        clear_log(); ack_delay = 0;
        src.push_back(64'hDEAD_BEEF_0000_0001);
        start(16'h0500, 8'd0);
        wait_done(20, n);
        vec++; if (n != 1) begin errs++; $display("FAIL zero_done_cycle got %0d exp 1", n); end
        @(negedge sys_clk);
        vec++; if (str_busy !== 1'b0) begin errs++; $display("FAIL zero_busy_after got %b exp 0", str_busy); end
        vec++; if (ready_seen != 0) begin errs++; $display("FAIL zero_ready got %0d cycles exp 0", ready_seen); end
        vec++; if (req_seen != 0) begin errs++; $display("FAIL zero_req got %0d cycles exp 0", req_seen); end
        vec++; if (accepted != 0) begin errs++; $display("FAIL zero_accepted got %0d exp 0", accepted); end
        src.delete();
    endtask

    task automatic test_start_while_busy();
        int n;
        clear_log(); ack_delay = 2;
        src.push_back({32'h0000_0D01, 32'h0000_0C01});
        src.push_back({32'h0000_0D02, 32'h0000_0C02});
        start(16'h0300, 8'd2);
        repeat (3) begin
            @(negedge sys_clk);
            str_start = 0;
        end
        str_base_addr = 16'h0700; str_count = 8'd5; str_start = 1;
        wait_done(100, n);
        @(negedge sys_clk);
        vec++; if (done_cnt != 1) begin errs++; $display("FAIL busy_start_done got %0d exp 1", done_cnt); end
        vec++; if (str_busy !== 1'b0) begin errs++; $display("FAIL busy_start_idle got %b exp 0", str_busy); end
        vec++; if (accepted != 2) begin errs++; $display("FAIL busy_start_accepted got %0d exp 2", accepted); end
        vec++; if (wa.size() != 4) begin errs++; $display("FAIL busy_start_nwrites got %0d exp 4", wa.size()); end
        else begin
            vec++; if (wa[3] !== 16'h0303 || wd[3] !== 32'h0000_0D02) begin errs++; $display("FAIL busy_start_last got %h/%h exp 0303/00000d02", wa[3], wd[3]); end
        end
    endtask

    task automatic test_excess();
        int n;
        clear_log(); ack_delay = 0;
        for (int i = 0; i < 3; i++) src.push_back({32'hE100_0000 + i, 32'hE000_0000 + i});
        start(16'h0600, 8'd2);
        wait_done(100, n);
        repeat (3) @(negedge sys_clk);
        vec++; if (accepted != 2) begin errs++; $display("FAIL excess_accepted got %0d exp 2", accepted); end
        vec++; if (ready_bad != 0) begin errs++; $display("FAIL excess_ready_after_full got %0d cycles exp 0", ready_bad); end
        vec++; if (src.size() != 1) begin errs++; $display("FAIL excess_left got %0d exp 1", src.size()); end
        vec++; if (wa.size() != 4) begin errs++; $display("FAIL excess_nwrites got %0d exp 4", wa.size()); end
        else begin
            vec++; if (wd[2] !== 32'hE000_0001) begin errs++; $display("FAIL excess_w2 got %h exp e0000001", wd[2]); end
        end
        src.delete();
    endtask

    task automatic test_reset_mid_job();
        int n, k;
        clear_log(); ack_delay = 2;
        src.push_back({32'h0000_4441, 32'h0000_4440});
        src.push_back({32'h0000_4451, 32'h0000_4450});
        start(16'h0400, 8'd2);
        k = 0;
        do begin
            @(negedge sys_clk);
            str_start = 0;
            k++;
        end while (!(mem_wr_req === 1'b1 && mem_addr === 16'h0401) && k < 50);
        vec++; if (k >= 50) begin errs++; $display("FAIL rstmid_reach_hi got timeout exp WR_HI"); end
        sys_rst = 1;
        #1;
        vec++; if (mem_wr_req !== 1'b0) begin errs++; $display("FAIL rstmid_req got %b exp 0", mem_wr_req); end
        vec++; if (str_busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got %b exp 0", str_busy); end
        vec++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin errs++; $display("FAIL rstmid_bus got %h/%h exp 0000/0", mem_addr, mem_wdata); end
        vec++; if (res_ready !== 1'b0) begin errs++; $display("FAIL rstmid_ready got %b exp 0", res_ready); end
        repeat (2) @(negedge sys_clk);
        sys_rst = 0;
        src.delete();
        @(negedge sys_clk);
        vec++; if (done_cnt != 0) begin errs++; $display("FAIL rstmid_no_done got %0d exp 0", done_cnt); end
        clear_log(); ack_delay = 0;
        src.push_back(64'h0000_00AA_0000_00BB);
        start(16'h0010, 8'd1);
        wait_done(50, n);
        vec++; if (n != 5) begin errs++; $display("FAIL rstmid_new_done got %0d exp 5", n); end
        vec++; if (wa.size() != 2) begin errs++; $display("FAIL rstmid_nwrites got %0d exp 2", wa.size()); end
        else begin
            vec++; if (wa[0] !== 16'h0010 || wd[0] !== 32'hBB || wa[1] !== 16'h0011 || wd[1] !== 32'hAA) begin errs++; $display("FAIL rstmid_writes got %h/%h %h/%h exp 0010/bb 0011/aa", wa[0], wd[0], wa[1], wd[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_wrap();
        test_zero_count();
        test_start_while_busy();
        test_excess();
        test_reset_mid_job();
        vec++; if (stable_err != 0) begin errs++; $display("FAIL req_stability got %0d changes exp 0", stable_err); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
